// File: rtl/gpio_in_capture.sv
// gpio_in_capture: samples the expansion-connector inputs into the fabric
// clock domain. Each bit is synchronised, debounced and edge-detected. Rising
// and falling edges raise sticky flags that software clears with a masked
// strobe. The strobe is acknowledged one cycle later.
//
// Optional build macro GPIO_IN_CAPTURE_IRQ_MASK_EN adds an irq_en input. Only
// bits enabled in irq_en contribute to irq. When the macro is undefined, every
// pending flag contributes to irq.
module gpio_in_capture #(
    parameter int DATA_WIDTH      = 8,
    parameter int DEBOUNCE_CYCLES = 1250,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] exp_in,
    output logic [DATA_WIDTH-1:0] exp_state,
    output logic [DATA_WIDTH-1:0] rise_pending,
    output logic [DATA_WIDTH-1:0] fall_pending,
    output logic                  irq,
`ifdef GPIO_IN_CAPTURE_IRQ_MASK_EN
    input  logic [DATA_WIDTH-1:0] irq_en,
`endif
    input  logic                  clear_req,
    input  logic [DATA_WIDTH-1:0] clear_mask,
    output logic                  clear_ack
);

    localparam logic [CNT_WIDTH-1:0]  CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] VEC_ZERO = {DATA_WIDTH{1'b0}};

    logic [DATA_WIDTH-1:0] sync1_r;
    logic [DATA_WIDTH-1:0] sync2_r;
    logic [DATA_WIDTH-1:0] state_r;
    logic [DATA_WIDTH-1:0] state_d_r;
    logic [CNT_WIDTH-1:0]  cnt_r [DATA_WIDTH];
    logic [DATA_WIDTH-1:0] rise_r;
    logic [DATA_WIDTH-1:0] fall_r;
    logic                  ack_r;

    logic [DATA_WIDTH-1:0] rise_evt_s;
    logic [DATA_WIDTH-1:0] fall_evt_s;
    logic [DATA_WIDTH-1:0] clr_s;
    logic [DATA_WIDTH-1:0] irq_en_s;

    // Two-flop synchroniser. Only sync2_r is used downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= VEC_ZERO;
            sync2_r <= VEC_ZERO;
        end else begin
            sync1_r <= exp_in;
            sync2_r <= sync1_r;
        end
    end

    // Per-bit debounce. A new level is accepted only after DEBOUNCE_CYCLES
    // consecutive mismatching cycles. Any agreeing cycle restarts the count.
    // The counter is cleared on acceptance, so it never passes CNT_LAST and
    // cannot wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
            state_r <= VEC_ZERO;
        end else begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                if (sync2_r[i] == state_r[i]) begin
                    cnt_r[i] <= CNT_ZERO;
                end else if (cnt_r[i] == CNT_LAST) begin
                    state_r[i] <= sync2_r[i];
                    cnt_r[i]   <= CNT_ZERO;
                end else begin
                    cnt_r[i] <= cnt_r[i] + CNT_ONE;
                end
            end
        end
    end

    // Edge events, masked clear vector and the interrupt enable in effect.
    always_comb begin
        rise_evt_s = state_r & ~state_d_r;
        fall_evt_s = ~state_r & state_d_r;
        if (clear_req) begin
            clr_s = clear_mask;
        end else begin
            clr_s = VEC_ZERO;
        end
`ifdef GPIO_IN_CAPTURE_IRQ_MASK_EN
        irq_en_s = irq_en;
`else
        irq_en_s = {DATA_WIDTH{1'b1}};
`endif
    end

    // Delayed debounced level, sticky flags and the clear acknowledge.
    // A new edge wins over a clear of the same bit in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_d_r <= VEC_ZERO;
            rise_r    <= VEC_ZERO;
            fall_r    <= VEC_ZERO;
            ack_r     <= 1'b0;
        end else begin
            state_d_r <= state_r;
            rise_r    <= (rise_r & ~clr_s) | rise_evt_s;
            fall_r    <= (fall_r & ~clr_s) | fall_evt_s;
            ack_r     <= clear_req;
        end
    end

    assign exp_state    = state_r;
    assign rise_pending = rise_r;
    assign fall_pending = fall_r;
    assign clear_ack    = ack_r;
    assign irq          = |((rise_r | fall_r) & irq_en_s);

endmodule

// File: tb/tb_gpio_in_capture.sv
// Testbench for gpio_in_capture. The bench runs with DATA_WIDTH=8 and
// DEBOUNCE_CYCLES=4. A behavioural model works from the history of applied
// inputs and is checked against the DUT on every falling edge. Directed
// phases add hand-computed literal expectations, and a random phase follows.
module tb_gpio_in_capture;

    localparam int DW   = 8;
    localparam int DB   = 4;
    localparam int HMAX = 8192;

    logic          clk;
    logic          rst;
    logic [DW-1:0] exp_in;
    logic [DW-1:0] exp_state;
    logic [DW-1:0] rise_pending;
    logic [DW-1:0] fall_pending;
    logic          irq;
    logic          clear_req;
    logic [DW-1:0] clear_mask;
    logic          clear_ack;
    logic [DW-1:0] en_mask;

    gpio_in_capture #(
        .DATA_WIDTH(DW),
        .DEBOUNCE_CYCLES(DB),
        .CNT_WIDTH(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .exp_in(exp_in),
        .exp_state(exp_state),
        .rise_pending(rise_pending),
        .fall_pending(fall_pending),
        .irq(irq),
`ifdef GPIO_IN_CAPTURE_IRQ_MASK_EN
        .irq_en(en_mask),
`endif
        .clear_req(clear_req),
        .clear_mask(clear_mask),
        .clear_ack(clear_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model state. hist[e] is the input applied before edge e, where edge 1
    // is the first edge after reset release. The synchronised value seen at
    // edge e is therefore hist[e-2].
    logic [DW-1:0] hist [HMAX];
    int            e_cnt;
    int            last_chg [DW];
    logic [DW-1:0] m_state, m_prev, m_rise, m_fall;
    logic          m_ack;

    task automatic model_reset();
        e_cnt   = 0;
        m_state = '0;
        m_prev  = '0;
        m_rise  = '0;
        m_fall  = '0;
        m_ack   = 1'b0;
        for (int b = 0; b < DW; b++) last_chg[b] = 0;
    endtask

    // Advance the model by one clock edge.
    task automatic model_edge();
        logic [DW-1:0] ev_r, ev_f, clr, nst;
        int k;
        bit flip;
        e_cnt = e_cnt + 1;
        if (e_cnt < HMAX) hist[e_cnt] = exp_in;
        ev_r = m_state & ~m_prev;
        ev_f = ~m_state & m_prev;
        clr  = clear_req ? clear_mask : '0;
        m_rise = (m_rise & ~clr) | ev_r;
        m_fall = (m_fall & ~clr) | ev_f;
        m_ack  = clear_req;
        // A bit flips when the last DB synchronised samples all oppose the
        // current level and all of them arrived after the previous flip.
        nst = m_state;
        for (int b = 0; b < DW; b++) begin
            flip = (e_cnt - DB + 1) > last_chg[b];
            for (int j = 0; j < DB; j++) begin
                k = e_cnt - 2 - j;
                if (((k >= 1) ? hist[k][b] : 1'b0) == m_state[b]) flip = 0;
            end
            if (flip) begin
                nst[b]      = ~m_state[b];
                last_chg[b] = e_cnt;
            end
        end
        m_prev  = m_state;
        m_state = nst;
    endtask

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: update the model at the rising edge, then return at the falling edge.
    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        @(negedge clk);
    endtask

    // Cycle-by-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        chk("model exp_state", exp_state, m_state);
        chk("model rise_pending", rise_pending, m_rise);
        chk("model fall_pending", fall_pending, m_fall);
        chk("model clear_ack", {7'd0, clear_ack}, {7'd0, m_ack});
        chk("model irq", {7'd0, irq}, {7'd0, |((m_rise | m_fall) & en_mask)});
    end

    initial begin
        rst        = 1'b1;
        exp_in     = '0;
        clear_req  = 1'b0;
        clear_mask = '0;
        en_mask    = 8'hFF;
        model_reset();

        // Reset
        repeat (3) step();
        rst = 1'b0;
        repeat (20) step();
        chk("reset exp_state", exp_state, 8'h00);
        chk("reset rise", rise_pending, 8'h00);
        chk("reset fall", fall_pending, 8'h00);
        chk("reset irq", {7'd0, irq}, 8'h00);
        chk("reset ack", {7'd0, clear_ack}, 8'h00);

        // Clean rise on bit 0
        exp_in = 8'h01;
        repeat (5) step();
        chk("rise N+4 state", exp_state, 8'h00);
        step();
        chk("rise N+5 state", exp_state, 8'h01);
        chk("rise N+5 flag", rise_pending, 8'h00);
        step();
        chk("rise N+6 flag", rise_pending, 8'h01);
        chk("rise N+6 irq", {7'd0, irq}, 8'h01);
        chk("rise fall", fall_pending, 8'h00);

        // Clear handshake
        clear_req = 1'b1; clear_mask = 8'h01;
        step();
        clear_req = 1'b0; clear_mask = 8'h00;
        chk("clear rise", rise_pending, 8'h00);
        chk("clear irq", {7'd0, irq}, 8'h00);
        chk("clear ack hi", {7'd0, clear_ack}, 8'h01);
        step();
        chk("clear ack lo", {7'd0, clear_ack}, 8'h00);

        // Glitch on bit 1, three cycles wide
        exp_in = 8'h03;
        repeat (3) step();
        exp_in = 8'h01;
        repeat (20) step();
        chk("glitch state", exp_state, 8'h01);
        chk("glitch rise", rise_pending, 8'h00);
        chk("glitch fall", fall_pending, 8'h00);
        chk("glitch irq", {7'd0, irq}, 8'h00);

        // Fall on bit 0 detected in the same cycle as a clear of bit 0
        exp_in = 8'h00;
        repeat (6) step();
        chk("collide state", exp_state, 8'h00);
        clear_req = 1'b1; clear_mask = 8'h01;
        step();
        clear_req = 1'b0; clear_mask = 8'h00;
        chk("collide fall", fall_pending, 8'h01);
        chk("collide ack", {7'd0, clear_ack}, 8'h01);
        clear_req = 1'b1; clear_mask = 8'hFF;
        step();
        clear_req = 1'b0; clear_mask = 8'h00;

        // Asynchronous reset mid-debounce
        exp_in = 8'h01;
        repeat (7) step();
        chk("pre-rst rise", rise_pending, 8'h01);
        exp_in = 8'h05;
        repeat (4) step();
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("async state", exp_state, 8'h00);
        chk("async rise", rise_pending, 8'h00);
        chk("async irq", {7'd0, irq}, 8'h00);
        step();
        rst = 1'b0;
        repeat (5) step();
        chk("redebounce N+4", exp_state, 8'h00);
        step();
        chk("redebounce N+5", exp_state, 8'h05);
        step();
        chk("redebounce rise", rise_pending, 8'h05);

        // Random phase
        for (int c = 0; c < 3000; c++) begin
            int rate;
            rate = ((c / 250) % 2 == 0) ? 12 : 3;
            for (int b = 0; b < DW; b++) begin
                if ($urandom_range(0, rate - 1) == 0) exp_in[b] = ~exp_in[b];
            end
            clear_req  = ($urandom_range(0, 7) == 0);
            clear_mask = 8'($urandom);
`ifdef GPIO_IN_CAPTURE_IRQ_MASK_EN
            if ($urandom_range(0, 63) == 0) en_mask = 8'($urandom);
`endif
            if ($urandom_range(0, 499) == 0) begin
                #($urandom_range(1, 4)) rst = 1'b1;
                model_reset();
                step();
                rst = 1'b0;
            end else begin
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gpio_in_capture.md
Name: gpio_in_capture

Overview:
- Input-direction companion to the GPIO output path: samples the expansion-connector inputs into the fabric clock domain.
- Per bit, it synchronises, debounces and edge-detects the input, then holds sticky rise/fall flags until software clears them.
- Sits between the exp_p/exp_n input pads and the PS-side register/interrupt logic.

Parameters:
- DATA_WIDTH, 8, number of GPIO input bits.
- DEBOUNCE_CYCLES, 1250, consecutive stable cycles required before accepting a new level (10 us at 125 MHz). Legal range 1..2^CNT_WIDTH-1.
- CNT_WIDTH, 16, width of each per-bit debounce counter.

Ports:
- clk  input  1  fabric clock
- rst  input  1  asynchronous, active-high reset
- exp_in  input  DATA_WIDTH  raw asynchronous pad inputs
- exp_state  output  DATA_WIDTH  debounced level, registered
- rise_pending  output  DATA_WIDTH  sticky rising-edge flags, registered
- fall_pending  output  DATA_WIDTH  sticky falling-edge flags, registered
- irq  output  1  OR of enabled pending flags
- clear_req  input  1  clear strobe, sampled each cycle
- clear_mask  input  DATA_WIDTH  bits to clear in both pending vectors when clear_req=1
- clear_ack  output  1  one-cycle acknowledge, registered

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset: sync stages, counters, exp_state, rise_pending, fall_pending and clear_ack go to 0 immediately on rst assertion, without a clock edge. irq=0 follows combinationally. Reset mid-count abandons the count and discards any pending flags.
- Synchroniser: 2-flop chain per bit, sync1 <= exp_in, sync2 <= sync1. Only sync2 is used downstream.
- Debounce, per bit:
  - If sync2 == exp_state: counter <= 0.
  - If sync2 != exp_state and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - If sync2 != exp_state and counter == DEBOUNCE_CYCLES-1: exp_state <= sync2 and counter <= 0.
  - Any mismatch interruption resets the counter, so glitches shorter than DEBOUNCE_CYCLES synchronised cycles are never reflected.
  - The counter saturates by construction and never wraps.
- Latency: a level change sampled at edge N appears on exp_state at edge N+1+DEBOUNCE_CYCLES (sync1 at N, sync2 at N+1, then DEBOUNCE_CYCLES mismatching cycles).
- Edge detect: exp_state_d holds exp_state delayed one cycle.
  - Rise (exp_state & ~exp_state_d) sets rise_pending at the next edge.
  - Fall (~exp_state & exp_state_d) sets fall_pending at the next edge.
  - Flags are therefore visible 1 cycle after exp_state changes.
- Clear: when clear_req=1, bits where clear_mask=1 are cleared in both pending vectors at the next edge. clear_ack=1 for exactly the following cycle.
  - clear_req held for k cycles produces k clears and k ack cycles.
  - clear_mask=0 still produces an ack.
- Simultaneous set and clear on the same bit in the same cycle: set wins, and the flag stays 1.
- Input high at reset release: exp_state starts at 0, so the high level is debounced and reported as a rise. This is intended, so software sees initial state.
- irq: combinational OR of (rise_pending | fall_pending) over enabled bits. Driven only from registers, so it is glitch-free.

Optional Feature:
- Macro GPIO_IN_CAPTURE_IRQ_MASK_EN.
- Defined: adds port irq_en (input, DATA_WIDTH), and irq = |((rise_pending | fall_pending) & irq_en). Pending flags still set regardless of irq_en.
- Undefined: no irq_en port; all bits contribute to irq.

Test Plan:
All tests use DATA_WIDTH=8 and DEBOUNCE_CYCLES=4.
- Reset: assert rst with exp_in=0x00, release, run 20 cycles -> exp_state=0x00, both pending=0x00, irq=0, clear_ack=0.
- Clean rise: exp_in 0x00->0x01 sampled at edge N -> exp_state=0x01 at edge N+5, rise_pending=0x01 at N+6, irq=1 at N+6. fall_pending stays 0x00.
- Glitch reject: exp_in[1]=1 for 3 cycles, then 0 -> exp_state, rise_pending and fall_pending unchanged for 20 cycles; irq=0.
- Clear handshake: with rise_pending=0x01, pulse clear_req=1 and clear_mask=0x01 for one cycle -> next edge rise_pending=0x00 and irq=0; clear_ack=1 for exactly one cycle.
- Set-vs-clear collision: arrange the fall on bit0 to be detected in the same cycle as clear_req with clear_mask=0x01 -> fall_pending[0]=1 afterwards, and clear_ack pulses.
- Async reset mid-debounce: assert rst between clock edges while a bit's counter=2 -> all outputs 0 before the next clk edge. After release, a held-high input re-debounces in the full 5 cycles.
